// File: rtl/audio_pkg.sv
// Shared types, constants and saturation helper for the audio mixer.
package audio_pkg;

  typedef enum logic [2:0] {
    IDLE, S_BEEP, S_A, S_B, S_C, S_SAT, S_DC, S_OUT
  } state_e;

  localparam logic [17:0]        W_SPK    = 18'd8192;
  localparam logic [17:0]        W_EAR    = 18'd2048;
  localparam logic [17:0]        W_MIC    = 18'd1024;
  localparam int                 AY_SHIFT = 6;
  localparam logic signed [18:0] OFFSET   = 19'sd16384;

  localparam logic [1:0] MODE_MONO = 2'd0;
  localparam logic [1:0] MODE_ABC  = 2'd1;
  localparam logic [1:0] MODE_ACB  = 2'd2;

  function automatic logic [15:0] sat16(input logic signed [18:0] v);
    if (v > 19'sd32767)       return 16'h7FFF;
    else if (v < -19'sd32768) return 16'h8000;
    else                      return v[15:0];
  endfunction

endpackage

// File: rtl/audio_mixer_dc_block.sv
// One-pole DC-blocking high-pass: y = x - x1 + y1 - (y1 >>> SHIFT), saturated.
module dc_block
  import audio_pkg::*;
#(
  parameter int SHIFT = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] x,
  output logic [15:0] y
);

  logic signed [15:0] x1_q, y1_q;
  logic signed [18:0] xs, x1s, y1s, fb, sum;

  assign xs  = 19'($signed(x));
  assign x1s = 19'(x1_q);
  assign y1s = 19'(y1_q);
  assign fb  = 19'(y1_q >>> SHIFT);
  assign sum = xs - x1s + y1s - fb;
  assign y   = sat16(sum);

  always_ff @(posedge clock) begin
    if (reset) begin
      x1_q <= '0;
      y1_q <= '0;
    end else if (en) begin
      x1_q <= $signed(x);
      y1_q <= $signed(y);
    end
  end

endmodule

// File: rtl/audio_mixer.sv
// Sample-rate mixer: snapshot on strobe, time-multiplexed accumulate,
// offset/saturate, optional DC block, then both words update on one edge.
module audio_mixer
  import audio_pkg::*;
#(
  parameter bit DC_EN    = 1'b1,
  parameter int DC_SHIFT = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        strobe,
  input  logic        speaker,
  input  logic        ear,
  input  logic        mic,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  c,
  input  logic [1:0]  mode,
  output logic [15:0] l,
  output logic [15:0] r,
  output logic        valid,
  output logic        busy
);

  state_e      state_q, state_d;
  logic        spk_q, ear_q, mic_q;
  logic [7:0]  a_q, b_q, c_q;
  logic [1:0]  mode_q;
  logic [17:0] accl_q, accl_d, accr_q, accr_d;
  logic [17:0] addl, addr, ch;
  logic [15:0] xl_q, xr_q, yl, yr, l_q, r_q;
  logic        valid_q, mono, acb;

  assign mono = (mode_q == MODE_MONO);
  assign acb  = (mode_q == MODE_ACB);

  always_comb begin
    state_d = state_q;
    accl_d  = accl_q;
    accr_d  = accr_q;
    addl    = '0;
    addr    = '0;
    ch      = '0;
    unique case (state_q)
      IDLE: if (strobe) begin
        state_d = S_BEEP;
        accl_d  = '0;
        accr_d  = '0;
      end
      S_BEEP: begin
        addl    = (spk_q ? W_SPK : 18'd0) + (ear_q ? W_EAR : 18'd0) + (mic_q ? W_MIC : 18'd0);
        addr    = addl;
        state_d = S_A;
      end
      S_A: begin
        ch      = 18'(a_q) << AY_SHIFT;
        addl    = ch;
        addr    = mono ? ch : 18'd0;
        state_d = S_B;
      end
      S_B: begin
        ch      = 18'(b_q) << AY_SHIFT;
        addl    = mono ? ch : acb ? 18'd0 : ch >> 1;
        addr    = mono ? ch : acb ? ch : ch >> 1;
        state_d = S_C;
      end
      S_C: begin
        ch      = 18'(c_q) << AY_SHIFT;
        addl    = mono ? ch : acb ? ch >> 1 : 18'd0;
        addr    = mono ? ch : acb ? ch >> 1 : ch;
        state_d = S_SAT;
      end
      S_SAT: state_d = S_DC;
      // The output load shares the S_DC edge so busy spans six cycles and
      // a new strobe is accepted seven clocks after the previous one.
      S_DC:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE) begin
      accl_d = accl_q + addl;
      accr_d = accr_q + addr;
    end
  end

  generate
    if (DC_EN) begin : g_dc
      logic dc_en;
      assign dc_en = (state_q == S_DC);
      dc_block #(.SHIFT(DC_SHIFT)) u_dc_l (
        .clock(clock), .reset(reset), .en(dc_en), .x(xl_q), .y(yl)
      );
      dc_block #(.SHIFT(DC_SHIFT)) u_dc_r (
        .clock(clock), .reset(reset), .en(dc_en), .x(xr_q), .y(yr)
      );
    end else begin : g_bypass
      assign yl = xl_q;
      assign yr = xr_q;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      {spk_q, ear_q, mic_q} <= '0;
      {a_q, b_q, c_q}       <= '0;
      mode_q  <= '0;
      accl_q  <= '0;
      accr_q  <= '0;
      xl_q    <= '0;
      xr_q    <= '0;
      l_q     <= '0;
      r_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      accl_q  <= accl_d;
      accr_q  <= accr_d;
      valid_q <= 1'b0;
      if (state_q == IDLE && strobe) begin
        {spk_q, ear_q, mic_q} <= {speaker, ear, mic};
        {a_q, b_q, c_q}       <= {a, b, c};
        mode_q <= mode;
      end
      if (state_q == S_SAT) begin
        xl_q <= sat16($signed({1'b0, accl_q}) - OFFSET);
        xr_q <= sat16($signed({1'b0, accr_q}) - OFFSET);
      end
      if (state_q == S_DC) begin
        l_q     <= yl;
        r_q     <= yr;
        valid_q <= 1'b1;
      end
    end
  end

  assign l     = l_q;
  assign r     = r_q;
  assign valid = valid_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: doc/audio_mixer.md
# audio_mixer

Sample-rate audio mixer that sits directly upstream of the I2S serialiser. It snapshots the beeper bits (speaker, EAR, MIC) and the three 8-bit PSG channel levels on each sample strobe, then mixes them into signed 16-bit left/right words. A time-multiplexed sequencer handles stereo placement, offset removal, saturation and an optional DC-blocking high-pass. It presents stable `l`/`r` words that the serialiser may sample at any time.

## Interface
Parameters:
- `DC_EN`, 1: 1 = DC-blocking filter in path, 0 = bypass (output = saturated mix).
- `DC_SHIFT`, 10: high-pass pole shift k, legal 4..14.

Ports:
- `clock`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `strobe`  in  1  one-clock sample request; typical 1 per 512 clocks.
- `speaker`  in  1  beeper bit.
- `ear`  in  1  tape EAR bit.
- `mic`  in  1  tape MIC bit.
- `a`, `b`, `c`  in  8 each  PSG channel levels, unsigned.
- `mode`  in  2  0 = mono, 1 = ABC, 2 = ACB, 3 = treated as ABC.
- `l`  out  16  left sample, two's complement.
- `r`  out  16  right sample, two's complement.
- `valid`  out  1  one-clock pulse when `l`/`r` update.
- `busy`  out  1  high while the sequencer is not IDLE.

## Operation
- **Snapshot.** In IDLE, `strobe` = 1 latches all audio inputs and `mode` into a snapshot register, clears accumulators `accl`/`accr` (18-bit unsigned) and enters S_BEEP.
- **S_BEEP.** Beeper term = speaker·8192 + ear·2048 + mic·1024 (max 11264). It is added to both accumulators.
- **S_A, S_B, S_C.** Each channel is scaled as ch<<6 (0..16320). Placement per mode:
  - mono: every channel adds full value to both sides.
  - ABC: A to left; C to right; B>>1 to both.
  - ACB: A to left; B to right; C>>1 to both.
- **S_SAT.** x = acc − 16384, computed in 19-bit signed. Saturate to [−32768, 32767]; only the positive limit is reachable (mono).
- **S_DC.**
  - DC_EN = 1, per side: y = x − x1 + y1 − (y1 >>> DC_SHIFT). Compute in 19-bit signed, saturate to 16 bits, then x1 ← x, y1 ← y.
  - DC_EN = 0: y = x.
- **S_OUT.** `l`/`r` ← y, `valid` = 1, return to IDLE.
- **Strobe handling.**
  - `strobe` while busy is ignored; it is not queued.
  - A strobe in the S_OUT cycle is also ignored.
- **Reset.**
  - Reset values: `l` = `r` = 0, `valid` = 0, `busy` = 0; filter state x1 = y1 = 0; snapshot and accumulators cleared.
  - Reset mid-sequence aborts to IDLE without updating `l`/`r`.

## Timing
- Strobe in cycle 0 → S_BEEP cycle 1 … S_OUT cycle 6.
- `l`/`r` registered with new value and `valid` high from edge ending cycle 6; latency 7 clocks.
- `busy` high cycles 1–6 inclusive.
- Max sample rate: one strobe per 7 clocks. Strobes at exactly 7-clock spacing are all accepted.
- `l`/`r` hold constant between `valid` pulses. The serialiser's asynchronous load never sees a half-updated word because both words update on the same edge.
- Input changes after the strobe cycle do not affect the pending sample.

## Structure
- **Shared package `audio_pkg`:**
  - State enum: IDLE, S_BEEP, S_A, S_B, S_C, S_SAT, S_DC, S_OUT.
  - Constants W_SPK = 8192, W_EAR = 2048, W_MIC = 1024, AY_SHIFT = 6, OFFSET = 16384.
  - Mode codes.
  - Function `sat16` (19-bit signed → 16-bit signed).
- **Sub-module `dc_block`:**
  - Ports: clock, reset, en, x[15:0], y[15:0]; parameter SHIFT.
  - Instantiated twice, left and right.
  - `en` pulses in S_DC.
  - Owns x1/y1; reset clears both.

## Test plan
- **Silence:** DC_EN = 0, mode = 1, all inputs 0, strobe → after 7 clocks l = r = 16'hC000, one `valid` pulse, busy high 6 clocks.
- **Beeper:** DC_EN = 0, speaker = 1 only → l = r = 16'hE000 (−8192); speaker = ear = mic = 1 → l = r = 16'hEC00 (−5120).
- **Stereo:** DC_EN = 0, mode = 1 (ABC), a = 255 only → l = 16'hFFC0, r = 16'hC000; same inputs with mode = 2 (ACB) give the same result. ABC with b = 255 only → l = r = 16'hDFE0.
- **Saturation:** DC_EN = 0, mode = 0, a = b = c = 255, all beeper bits 1 → l = r = 16'h7FFF.
- **DC filter:** DC_EN = 1, DC_SHIFT = 10, constant silence input, repeated strobes → y = −16384, then −16368, then −16352.02→−16352 (arithmetic shift), monotonically toward 0. Check 2000 samples for no overflow or sign flip.
- **Protocol:** strobe asserted again at cycles 3 and 6 after an accepted strobe → ignored, single `valid`. Reset asserted at cycle 4 → `busy` = 0 next cycle, `l`/`r` = 0, no `valid`.
